// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-port arbiter.
// Optional feature macro used by the arbiter: FIFO_ARB_AFULL_EN (almost-full output and gating).
package fifo_arb_pkg;

    localparam int unsigned ARB_NREQ  = 4;
    localparam int unsigned ARB_DW    = 4;
    localparam int unsigned ARB_DEPTH = 8;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << width) < 64'(value)) begin
                width = width + 1;
            end
        end
        return width;
    endfunction

    // Index width for an N-entry vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    localparam int unsigned ARB_CW = clog2(ARB_DEPTH + 1);

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Rotate-priority one-hot picker: first asserted request after rr_ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = ARB_NREQ,
    localparam int unsigned IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW-1:0] cand;

    // Scan rr_ptr+1, rr_ptr+2, ... modulo NREQ and take the first request seen.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(rr_ptr) + k) % NREQ);
            if (enable && !valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin write-port arbiter and occupancy tracker for the single-port FIFO.
// Optional macro FIFO_ARB_AFULL_EN adds AFULL / almost_full; above the threshold
// only producer 0 may be granted.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = ARB_NREQ,
    parameter int unsigned DW    = ARB_DW,
    parameter int unsigned DEPTH = ARB_DEPTH,
`ifdef FIFO_ARB_AFULL_EN
    parameter int unsigned AFULL = DEPTH - 2,
`endif
    localparam int unsigned CW   = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  gnt,
    input  logic             pop,
    output logic             pop_ack,
    output logic             fifo_we,
    output logic             fifo_re,
    output logic [DW-1:0]    fifo_data,
    output logic [CW-1:0]    count,
`ifdef FIFO_ARB_AFULL_EN
    output logic             almost_full,
`endif
    output logic             full,
    output logic             empty
);

    localparam int unsigned IW = idx_width(NREQ);

    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            grant_en;
    logic [DW-1:0]   winner_data;

    // Occupancy flags straight from the committed count.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

`ifdef FIFO_ARB_AFULL_EN
    assign almost_full = (count >= CW'(AFULL));

    // Above the almost-full threshold only producer 0 competes.
    always_comb begin
        pick_req    = req;
        if (almost_full) begin
            pick_req    = '0;
            pick_req[0] = req[0];
        end
    end
`else
    assign pick_req = req;
`endif

    // No grants or pops are accepted while reset is held.
    assign grant_en = rst & ~full;
    assign pop_ack  = rst & pop & ~empty;
    assign gnt      = pick_gnt;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req    (pick_req),
        .rr_ptr (rr_ptr),
        .enable (grant_en),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // One-hot mux of the winning producer's data slice.
    always_comb begin
        winner_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                winner_data = req_data[i*DW +: DW];
            end
        end
    end

    // FIFO command registers, round-robin pointer and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_we   <= 1'b0;
            fifo_re   <= 1'b0;
            fifo_data <= '0;
            count     <= '0;
            rr_ptr    <= IW'(NREQ - 1);
        end else begin
            fifo_we <= pick_valid;
            fifo_re <= pop_ack;
            if (pick_valid) begin
                fifo_data <= winner_data;
                rr_ptr    <= pick_idx;
            end
            case ({pick_valid, pop_ack})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
